updown_counter_param: RTL and testbench
=======================================

# updown_counter_param

Parametrised synchronous up/down counter. It generalises the team's 3-bit up/down counter with configurable width and modulus, variable step, parallel load, count enable, and a wrap or saturate mode. It also reports terminal-count and overflow/underflow status. It is the common counting primitive for timers, address generators and credit counters in the counter library.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (2..32)
- MAX_VAL, 2**WIDTH-1, largest legal count; the modulus is MAX_VAL+1 (1..2**WIDTH-1)
- RST_VAL, 0, count value after reset (must be <= MAX_VAL)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high; clock clk
- en  in  1  count enable
- up  in  1  direction: 1 = up, 0 = down
- step  in  WIDTH  increment/decrement magnitude; 0 = hold
- sat  in  1  mode: 1 = saturate at bounds, 0 = wrap modulo MAX_VAL+1
- load  in  1  parallel load strobe
- load_val  in  WIDTH  value to load
- clr_flags  in  1  clears the sticky flags
- count  out  WIDTH  current count (registered)
- at_max  out  1  count == MAX_VAL (combinational decode of count)
- at_min  out  1  count == 0 (combinational decode of count)
- tc  out  1  one-cycle pulse: the previous update crossed or hit a bound (registered)
- ovf  out  1  sticky: an up-count exceeded MAX_VAL
- udf  out  1  sticky: a down-count went below 0

## Operation
- Priority per cycle: rst > load > en. The sticky flags are handled independently; see below.
- rst: count = RST_VAL, tc = 0, ovf = 0, udf = 0.
- load: count = min(load_val, MAX_VAL); tc = 0; flags unchanged.
- en=0 and no load: count holds; tc = 0.
- Effective step s = min(step, MAX_VAL). Compute in WIDTH+1 bits to avoid carry loss.
- Up, count + s <= MAX_VAL: count += s. tc = 1 if the result == MAX_VAL and s != 0, else 0.
- Up, count + s > MAX_VAL: tc = 1 and ovf set.
  - wrap: count = count + s - (MAX_VAL+1)
  - saturate: count = MAX_VAL
- Down, s <= count: count -= s. tc = 1 if the result == 0 and s != 0, else 0.
- Down, s > count: tc = 1 and udf set.
  - wrap: count = count + (MAX_VAL+1) - s
  - saturate: count = 0
- Saturated and still pushing (e.g. count = MAX_VAL, up, s > 0, sat = 1): count holds, tc = 1 each cycle, ovf set.
- clr_flags clears ovf/udf next cycle. If a set event occurs in the same cycle, set wins.
- MAX_VAL = 1 degenerates to a toggle counter; the same rules apply.
- up, sat and step are sampled each cycle with no state of their own. Changing them mid-count takes effect on the next enabled edge.

## Timing
- Single-cycle latency: inputs sampled at edge N are reflected in count/tc/ovf/udf after edge N.
- at_max/at_min follow count in the same cycle, with no extra latency.
- tc is high for exactly one cycle per qualifying update. It is high on consecutive cycles only when consecutive updates qualify.
- Reset mid-count takes effect at the next edge regardless of en/load. An asserted rst overrides a simultaneous load.
- No combinational path from inputs to outputs.

## Structure
- Shared package `counter_pkg`:
  - count_dir_e (DIR_DOWN, DIR_UP)
  - count_mode_e (MODE_WRAP, MODE_SAT)
  - function clamp_to_max
- One sub-module, `updown_next_calc`: purely combinational next-count, tc and ovf/udf-event computation, parametrised by WIDTH/MAX_VAL. The top module holds the registers, priority logic and sticky flags.
- Parameter legality (RST_VAL <= MAX_VAL < 2**WIDTH) is checked by an elaboration-time assertion.

## Test plan
- WIDTH=3, MAX_VAL=7: rst, then en=1, up=1, step=1 for 9 cycles → count 1..7, 0, 1; tc high on the cycles count becomes 7 and 0; ovf set after the wrap.
- WIDTH=4, MAX_VAL=9, sat=0, count=8, up, step=3 → count=1, tc=1, ovf=1. Then down, step=5 → count=6, udf=1.
- sat=1, MAX_VAL=9, count=7, up, step=5 for 3 cycles → count 9, 9, 9; tc high all 3 cycles; ovf=1. Then clr_flags alone → ovf=0.
- load=1, load_val=15 with MAX_VAL=9 and en=1 → count=9, tc=0. Same cycle with rst=1 → count=RST_VAL, all flags 0.
- count=0, down, step=0, en=1 → count holds, tc=0, udf unchanged. Step=12 (>MAX_VAL=9), wrap → clamped s=9, count=1, udf=1.
- clr_flags and an underflow event in the same cycle → udf stays 1. clr_flags on the next cycle → udf=0.

Source files
------------

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared types and helpers for the counter library.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } count_dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } count_mode_e;

    // Wide enough for any WIDTH up to 32 plus a carry bit; callers size-cast the result.
    function automatic logic [32:0] clamp_to_max(input logic [32:0] v, input logic [32:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/updown_next_calc.sv
`default_nettype none
// ============================================================================
// Module      : updown_next_calc
// Description : Combinational next-count, terminal-count and ovf/udf events.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_next_calc
    import counter_pkg::*;
#(
    parameter int          WIDTH   = 8,
    parameter logic [31:0] MAX_VAL = 32'((64'd1 << WIDTH) - 64'd1)
) (
    input  logic [WIDTH-1:0] count_i,
    input  count_dir_e       dir_i,
    input  count_mode_e      mode_i,
    input  logic [WIDTH-1:0] step_i,
    output logic [WIDTH-1:0] next_o,
    output logic             tc_o,
    output logic             ovf_evt_o,
    output logic             udf_evt_o
);

    localparam logic [WIDTH:0] c_max  = {1'b0, MAX_VAL[WIDTH-1:0]};
    localparam logic [WIDTH:0] c_one  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] c_mod  = c_max + c_one;
    localparam logic [WIDTH:0] c_zero = '0;

    logic [WIDTH:0] w_cnt;
    logic [WIDTH:0] w_step;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;
    logic [WIDTH:0] w_res;

    assign w_cnt  = {1'b0, count_i};
    assign w_step = (WIDTH+1)'(clamp_to_max(33'(step_i), 33'(c_max)));
    assign w_sum  = w_cnt + w_step;
    assign w_diff = w_cnt - w_step;

    always_comb begin
        w_res     = w_cnt;
        tc_o      = 1'b0;
        ovf_evt_o = 1'b0;
        udf_evt_o = 1'b0;
        if (dir_i == DIR_UP) begin
            if (w_sum > c_max) begin
                ovf_evt_o = 1'b1;
                tc_o      = 1'b1;
                w_res     = (mode_i == MODE_SAT) ? c_max : (w_sum - c_mod);
            end else begin
                w_res = w_sum;
                tc_o  = (w_sum == c_max) && (w_step != c_zero);
            end
        end else begin
            if (w_step > w_cnt) begin
                udf_evt_o = 1'b1;
                tc_o      = 1'b1;
                // Add the modulus first so the WIDTH+1-bit intermediate never goes negative.
                w_res     = (mode_i == MODE_SAT) ? c_zero : (w_cnt + c_mod - w_step);
            end else begin
                w_res = w_diff;
                tc_o  = (w_diff == c_zero) && (w_step != c_zero);
            end
        end
    end

    assign next_o = WIDTH'(w_res);

endmodule
`default_nettype wire

// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_param
// Description : Parametrised up/down counter with load, wrap/saturate, status.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int          WIDTH   = 8,
    parameter logic [31:0] MAX_VAL = 32'((64'd1 << WIDTH) - 64'd1),
    parameter logic [31:0] RST_VAL = 32'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] step,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             tc,
    output logic             ovf,
    output logic             udf
);

    if ((WIDTH < 2) || (WIDTH > 32) || (MAX_VAL < 32'd1) ||
        ((WIDTH < 32) && (MAX_VAL >= (32'd1 << WIDTH))) || (RST_VAL > MAX_VAL)) begin : g_bad_params
        $error("updown_counter_param: illegal WIDTH/MAX_VAL/RST_VAL combination");
    end

    localparam logic [WIDTH-1:0] c_max_val = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_rst_val = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic [WIDTH-1:0] w_next;
    logic             w_tc;
    logic             w_ovf_evt;
    logic             w_udf_evt;
    logic             w_update;

    updown_next_calc #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_next_calc (
        .count_i   (count_q),
        .dir_i     (count_dir_e'(up)),
        .mode_i    (count_mode_e'(sat)),
        .step_i    (step),
        .next_o    (w_next),
        .tc_o      (w_tc),
        .ovf_evt_o (w_ovf_evt),
        .udf_evt_o (w_udf_evt)
    );

    // A load suppresses the count update, so it also suppresses its flag events.
    assign w_update = en && !load;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = WIDTH'(clamp_to_max(33'(load_val), 33'(MAX_VAL)));
        end else if (en) begin
            count_d = w_next;
            tc_d    = w_tc;
        end
        ovf_d = (w_update && w_ovf_evt) || (ovf_q && !clr_flags);
        udf_d = (w_update && w_udf_evt) || (udf_q && !clr_flags);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= c_rst_val;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign count  = count_q;
    assign at_max = (count_q == c_max_val);
    assign at_min = (count_q == '0);
    assign tc     = tc_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_counter_param
// Description : Directed bench for an 8-state counter and a mod-10 counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_counter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Instance A: WIDTH=3, MAX_VAL=7, RST_VAL=0
    logic       a_rst, a_en, a_up, a_sat, a_load, a_clr;
    logic [2:0] a_step, a_lval, a_count;
    logic       a_at_max, a_at_min, a_tc, a_ovf, a_udf;

    // Instance B: WIDTH=4, MAX_VAL=9, RST_VAL=2
    logic       b_rst, b_en, b_up, b_sat, b_load, b_clr;
    logic [3:0] b_step, b_lval, b_count;
    logic       b_at_max, b_at_min, b_tc, b_ovf, b_udf;

    updown_counter_param #(.WIDTH(3), .MAX_VAL(32'd7), .RST_VAL(32'd0)) dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .step(a_step), .sat(a_sat),
        .load(a_load), .load_val(a_lval), .clr_flags(a_clr), .count(a_count),
        .at_max(a_at_max), .at_min(a_at_min), .tc(a_tc), .ovf(a_ovf), .udf(a_udf)
    );

    updown_counter_param #(.WIDTH(4), .MAX_VAL(32'd9), .RST_VAL(32'd2)) dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .up(b_up), .step(b_step), .sat(b_sat),
        .load(b_load), .load_val(b_lval), .clr_flags(b_clr), .count(b_count),
        .at_max(b_at_max), .at_min(b_at_min), .tc(b_tc), .ovf(b_ovf), .udf(b_udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected state of instance B: count, tc, ovf, udf
    task automatic chk_b(input string tag, input int c, input bit t, input bit o, input bit u);
        chk({tag, ".count"}, 32'(b_count), 32'(c));
        chk({tag, ".tc"},    32'(b_tc),    32'(t));
        chk({tag, ".ovf"},   32'(b_ovf),   32'(o));
        chk({tag, ".udf"},   32'(b_udf),   32'(u));
    endtask

    task automatic setb(input bit ld, input int lv, input bit e, input bit u,
                        input int s, input bit st, input bit cl);
        b_load = ld; b_lval = 4'(lv); b_en = e; b_up = u;
        b_step = 4'(s); b_sat = st; b_clr = cl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst = 1'b1; a_en = 1'b0; a_up = 1'b0; a_sat = 1'b0; a_load = 1'b0; a_clr = 1'b0;
        a_step = 3'd0; a_lval = 3'd0;
        b_rst = 1'b1;
        setb(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tick();

        // Reset state
        chk("a_rst.count", 32'(a_count), 32'd0);
        chk("a_rst.at_min", 32'(a_at_min), 32'd1);
        chk("a_rst.at_max", 32'(a_at_max), 32'd0);
        chk("a_rst.tc", 32'(a_tc), 32'd0);
        chk("a_rst.ovf", 32'(a_ovf), 32'd0);
        chk_b("b_rst", 2, 0, 0, 0);

        // A: up by 1 for 9 cycles, wrapping 7 -> 0
        a_rst = 1'b0; b_rst = 1'b0;
        a_en = 1'b1; a_up = 1'b1; a_step = 3'd1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("a_up.count", 32'(a_count), 32'(k % 8));
            chk("a_up.tc", 32'(a_tc), 32'((k == 7) || (k == 8)));
            chk("a_up.ovf", 32'(a_ovf), 32'(k >= 8));
            chk("a_up.at_max", 32'(a_at_max), 32'(k == 7));
        end
        a_en = 1'b0;
        tick();
        chk("a_hold.tc", 32'(a_tc), 32'd0);
        chk("a_hold.count", 32'(a_count), 32'd1);

        // B: wrap up 8+3 -> 1, then wrap down 1-5 -> 6
        setb(1, 8, 0, 0, 0, 0, 0); tick(); chk_b("b_load8", 8, 0, 0, 0);
        setb(0, 0, 1, 1, 3, 0, 0); tick(); chk_b("b_wrap_up", 1, 1, 1, 0);
        setb(0, 0, 1, 0, 5, 0, 0); tick(); chk_b("b_wrap_dn", 6, 1, 1, 1);

        // B: saturate at 9 for three cycles, then clear flags alone
        setb(1, 7, 0, 0, 0, 0, 0); tick(); chk_b("b_load7", 7, 0, 1, 1);
        setb(0, 0, 1, 1, 5, 1, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_b("b_sat_up", 9, 1, 1, 1);
            chk("b_sat_up.at_max", 32'(b_at_max), 32'd1);
        end
        setb(0, 0, 0, 1, 5, 1, 1); tick(); chk_b("b_clr", 9, 0, 0, 0);

        // B: load clamps to MAX_VAL and beats en; rst beats load
        setb(1, 15, 1, 1, 1, 0, 0); tick(); chk_b("b_load15", 9, 0, 0, 0);
        setb(0, 0, 1, 1, 1, 0, 0); tick(); chk_b("b_ovf_set", 0, 1, 1, 0);
        setb(1, 15, 1, 1, 1, 0, 0); b_rst = 1'b1; tick(); chk_b("b_rst_load", 2, 0, 0, 0);
        b_rst = 1'b0;

        // B: step 0 holds, oversize step clamps to 9 and wraps down
        setb(1, 0, 0, 0, 0, 0, 0); tick(); chk_b("b_load0", 0, 0, 0, 0);
        setb(0, 0, 1, 0, 0, 0, 0); tick(); chk_b("b_step0", 0, 0, 0, 0);
        setb(0, 0, 1, 0, 12, 0, 0); tick(); chk_b("b_step12", 1, 1, 0, 1);

        // B: clear and underflow in the same cycle, set wins; then clear alone
        setb(0, 0, 1, 0, 3, 0, 1); tick(); chk_b("b_clr_vs_udf", 8, 1, 0, 1);
        setb(0, 0, 0, 0, 3, 0, 1); tick(); chk_b("b_clr_udf", 8, 0, 0, 0);

        // B: exact hits of the bounds raise tc without flag events
        setb(1, 3, 0, 0, 0, 0, 0); tick(); chk_b("b_load3", 3, 0, 0, 0);
        setb(0, 0, 1, 0, 3, 0, 0); tick(); chk_b("b_hit0", 0, 1, 0, 0);
        chk("b_hit0.at_min", 32'(b_at_min), 32'd1);
        setb(1, 6, 0, 0, 0, 0, 0); tick(); chk_b("b_load6", 6, 0, 0, 0);
        setb(0, 0, 1, 1, 3, 0, 0); tick(); chk_b("b_hit9", 9, 1, 0, 0);
        setb(0, 0, 1, 0, 4, 1, 0); tick(); chk_b("b_dn_sat_ok", 5, 0, 0, 0);
        setb(0, 0, 1, 0, 7, 1, 0); tick(); chk_b("b_dn_sat", 0, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
